// File: rtl/scan_chain_ctrl_if.sv
// Register-side and chain-side signals of one scan_chain_ctrl instance.
// The controller binds to the slave modport. The host/chain side binds to master.
interface scan_chain_ctrl_if #(
   parameter int CHAIN_LEN = 16
) ();
   logic                 start;
   logic                 abort;
   logic [CHAIN_LEN-1:0] pat_in;
   logic                 so;
   logic                 te;
   logic                 ti;
   logic                 busy;
   logic                 done;
   logic [CHAIN_LEN-1:0] resp_out;

   modport master (
      output start, abort, pat_in, so,
      input  te, ti, busy, done, resp_out
   );

   modport slave (
      input  start, abort, pat_in, so,
      output te, ti, busy, done, resp_out
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan-test sequencer: shifts a pattern into one chain, pulses a capture cycle,
// then shifts the response out into a parallel register.
module scan_chain_ctrl #(
   parameter int CHAIN_LEN = 16,
   parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
   input logic           clk,
   input logic           rst,
   scan_chain_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_IN,
      CAPTURE,
      SHIFT_OUT,
      FINISH
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [CHAIN_LEN-1:0] pat;
   logic [CHAIN_LEN-1:0] resp;
   logic                 te_q;
   logic                 ti_q;
   logic                 busy_q;
   logic                 done_q;

   // NOTE: state and outputs are all assigned with <= in the one clocked
   // block, so every branch sees the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         pat    <= '0;
         resp   <= '0;
         te_q   <= 1'b0;
         ti_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state  <= SHIFT_IN;
                  pat    <= bus.pat_in;
                  cnt    <= '0;
                  te_q   <= 1'b1;
                  ti_q   <= bus.pat_in[CHAIN_LEN-1];
                  busy_q <= 1'b1;
               end
            end

            SHIFT_IN: begin
               if (bus.abort) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  te_q   <= 1'b0;
                  ti_q   <= 1'b0;
                  busy_q <= 1'b0;
               end else if (cnt == LAST) begin
                  state <= CAPTURE;
                  te_q  <= 1'b0;
                  ti_q  <= 1'b0;
               end else begin
                  // The MSB of pat always holds the bit currently on ti.
                  cnt  <= cnt + 1'b1;
                  ti_q <= pat[CHAIN_LEN-2];
                  pat  <= pat << 1;
               end
            end

            CAPTURE: begin
               if (bus.abort) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  state <= SHIFT_OUT;
                  cnt   <= '0;
                  te_q  <= 1'b1;
               end
            end

            SHIFT_OUT: begin
               if (bus.abort) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  te_q   <= 1'b0;
                  busy_q <= 1'b0;
               end else begin
                  // so is the pre-shift Q of the last flop, which walks down the chain.
                  resp[LAST - cnt] <= bus.so;
                  if (cnt == LAST) begin
                     state  <= FINISH;
                     te_q   <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end

            FINISH: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               cnt    <= '0;
               te_q   <= 1'b0;
               ti_q   <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.te       = te_q;
   assign bus.ti       = ti_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.resp_out = resp;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 4-flop behavioural scan chain and
// a response scoreboard that is filled at START and drained on DONE.
module tb_scan_chain_ctrl;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   scan_chain_ctrl_if #(.CHAIN_LEN(N)) bus ();

   scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Mux-D scan flops: shift toward flop N-1 when te, else load functional D.
   logic [N-1:0] chain_q = '0;
   logic [N-1:0] func_d  = '0;
   logic         loopback = 1'b0;

   always @(posedge clk)
      chain_q <= bus.te ? {chain_q[N-2:0], bus.ti} : (loopback ? chain_q : func_d);

   assign bus.so = chain_q[N-1];

   int           total = 0;
   int           bad   = 0;
   logic [N-1:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample #1 after the edge and drain the scoreboard on DONE.
   task automatic step();
      @(posedge clk);
      #1;
      if (bus.done) begin
         if (sb_q.size() == 0) check("done_without_op", {31'b0, bus.done}, 32'd0);
         else                  check("resp_out", {28'b0, bus.resp_out}, {28'b0, sb_q.pop_front()});
      end
   endtask

   // Runs one full operation from its cycle 0 through cycle 2N+3 (idle again).
   task automatic do_op(input logic [N-1:0] pat, input logic [N-1:0] exp_resp,
                        input bit hold, input bit with_abort);
      logic te_e;
      logic ti_e;
      bus.pat_in = pat;
      bus.start  = 1'b1;
      bus.abort  = with_abort;
      sb_q.push_back(exp_resp);
      for (int c = 1; c <= 2 * N + 2; c++) begin
         step();
         if (c == 1) begin
            bus.abort = 1'b0;
            if (hold) bus.pat_in = ~pat;
            else      bus.start  = 1'b0;
         end
         te_e = ((c >= 1) && (c <= N)) || ((c >= N + 2) && (c <= 2 * N + 1));
         ti_e = (c <= N) ? pat[N-c] : 1'b0;
         check($sformatf("cyc%0d_te_ti_busy_done", c),
               {28'b0, bus.te, bus.ti, bus.busy, bus.done},
               {28'b0, te_e, ti_e, 1'b1, (c == 2 * N + 2)});
      end
      step();
      check("idle_after_op", {28'b0, bus.te, bus.ti, bus.busy, bus.done}, 32'd0);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.abort  = 1'b0;
      bus.pat_in = '0;

      // Reset state
      step();
      step();
      check("reset_outputs", {28'b0, bus.te, bus.ti, bus.busy, bus.done}, 32'd0);
      check("reset_resp", {28'b0, bus.resp_out}, 32'd0);
      rst = 1'b0;
      step();
      check("idle_outputs", {28'b0, bus.te, bus.ti, bus.busy, bus.done}, 32'd0);

      // 1. Basic capture of functional D
      func_d = 4'b0110;
      do_op(4'b1011, 4'b0110, 1'b0, 1'b0);

      // 2. Loopback, back-to-back operations
      loopback = 1'b1;
      do_op(4'b1011, 4'b1011, 1'b0, 1'b0);
      do_op(4'b0100, 4'b0100, 1'b0, 1'b0);

      // 3. START held high and PAT_IN scrambled while busy
      do_op(4'b1011, 4'b1011, 1'b1, 1'b0);
      do_op(4'b0100, 4'b0100, 1'b0, 1'b0);

      // 4. ABORT in cycle 7 (second SHIFT_OUT cycle)
      loopback   = 1'b0;
      func_d     = 4'b1001;
      bus.pat_in = 4'b0011;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 2; c <= 7; c++) step();
      check("pre_abort_te", {31'b0, bus.te}, 32'd1);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      check("abort_outputs", {28'b0, bus.te, bus.ti, bus.busy, bus.done}, 32'd0);
      check("abort_resp", {28'b0, bus.resp_out}, 32'hC);
      for (int c = 0; c < 4; c++) step();
      check("abort_no_done", {28'b0, bus.te, bus.ti, bus.busy, bus.done}, 32'd0);

      // 5. Reset asserted in cycle 3
      loopback   = 1'b1;
      bus.pat_in = 4'b1110;
      bus.start  = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      check("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
      rst = 1'b1;
      step();
      check("midop_reset_outputs", {28'b0, bus.te, bus.ti, bus.busy, bus.done}, 32'd0);
      check("midop_reset_resp", {28'b0, bus.resp_out}, 32'd0);
      rst = 1'b0;
      do_op(4'b0110, 4'b0110, 1'b0, 1'b0);

      // 6. START and ABORT together in IDLE
      do_op(4'b1001, 4'b1001, 1'b0, 1'b1);

      check("scoreboard_empty", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer for a chain of scan flip-flops (mux-D flops with TE/TI scan inputs). Given a start request and a parallel test pattern, it runs one complete scan test:
- serially shifts the pattern into the chain,
- pulses one functional capture cycle,
- shifts the captured response back out into a parallel register.

It sits between the test/debug register interface and the TE/TI/SO pins of one scan chain. It owns the chain's test-enable for the whole operation.

## Interface

Parameters:
- CHAIN_LEN, 16, number of flops in the controlled chain (≥2)
- CNT_W, $clog2(CHAIN_LEN), width of the internal bit counter

Ports:
- CLK  in  1  sole clock; shared with the scan chain flops
- RST  in  1  synchronous, active-high reset
- START  in  1  request to begin a scan operation; honoured only in IDLE
- ABORT  in  1  terminate the current operation
- PAT_IN  in  CHAIN_LEN  pattern; bit j is destined for chain flop j; sampled on the START-accept edge
- SO  in  1  scan-out: Q of chain flop CHAIN_LEN-1
- TE  out  1  test enable to every chain flop
- TI  out  1  scan-in to chain flop 0
- BUSY  out  1  high in any state except IDLE
- DONE  out  1  one-cycle pulse when RESP_OUT becomes valid
- RESP_OUT  out  CHAIN_LEN  captured response; bit j is the value flop j captured

## Operation

- FSM states:
  - IDLE
  - SHIFT_IN
  - CAPTURE
  - SHIFT_OUT
  - FINISH
- Moore outputs: TE, TI, BUSY and DONE are decoded from registered state only. There is no combinational input-to-output path.
- Pattern shift register: PAT_IN is loaded into an internal register when START is accepted.
- IDLE:
  - Outputs: TE=0, TI=0.
  - START=1 → load PAT_IN, clear the counter, go to SHIFT_IN.
- SHIFT_IN (CHAIN_LEN cycles, counter k=0..CHAIN_LEN-1):
  - TE=1, TI = pattern bit [CHAIN_LEN-1-k] (MSB first).
  - After the last cycle, chain flop j holds PAT_IN[j].
  - k=CHAIN_LEN-1 → CAPTURE.
- CAPTURE (1 cycle):
  - TE=0, TI=0.
  - The chain loads its functional D inputs.
  - Clear the counter, go to SHIFT_OUT.
- SHIFT_OUT (CHAIN_LEN cycles, k=0..CHAIN_LEN-1):
  - TE=1, TI=0.
  - On each edge, SO is stored into RESP_OUT[CHAIN_LEN-1-k]. This is the pre-shift value of flop CHAIN_LEN-1-k.
  - k=CHAIN_LEN-1 → FINISH.
- FINISH (1 cycle):
  - DONE=1, TE=0, then go to IDLE.
  - RESP_OUT is complete from this cycle on.
- RESP_OUT:
  - Updated only in SHIFT_OUT.
  - Holds its value until the next operation's SHIFT_OUT begins.
  - It is not valid during SHIFT_OUT.
- ABORT:
  - In SHIFT_IN, CAPTURE or SHIFT_OUT: go to IDLE on the next edge.
  - DONE is not pulsed. RESP_OUT bits already written stay written.
  - ABORT has priority over counter-driven transitions.
  - ABORT in IDLE or FINISH has no effect.
- START outside IDLE is ignored. It is neither queued nor counted.
- START and ABORT together in IDLE: START is accepted.

## Timing

- Reset values:
  - state=IDLE, counter=0, pattern reg=0
  - TE=0, TI=0, BUSY=0, DONE=0, RESP_OUT=0
- Reset applies on any edge with RST=1, mid-operation included. The chain contents are then undefined; the next START runs a full sequence.
- Cycle numbering: cycle 0 is the cycle START is sampled high in IDLE.
  - Cycles 1..N: SHIFT_IN (N=CHAIN_LEN)
  - Cycle N+1: CAPTURE
  - Cycles N+2..2N+1: SHIFT_OUT
  - Cycle 2N+2: FINISH/DONE
- BUSY covers cycles 1..2N+2.
- Earliest next START is sampled in cycle 2N+3, giving a throughput of one operation per 2N+3 cycles.
- TE toggles only on state boundaries:
  - 0→1 entering SHIFT_IN
  - 1→0 for CAPTURE
  - 0→1 for SHIFT_OUT
  - 1→0 at FINISH
- Counter wraps only via explicit clear. It never exceeds CHAIN_LEN-1.

## Test plan

Bench: CHAIN_LEN=4, chain built from 4 scan flops, bench drives each functional D_j.

1. Basic: PAT_IN=4'b1011, D=4'b0110, pulse START → TI over cycles 1..4 = 1,0,1,1 with TE=1; cycle 5 TE=0; DONE in cycle 10 only; RESP_OUT=4'b0110; BUSY high cycles 1..10.
2. Loopback: D_j tied to Q_j, PAT_IN=4'b1011 → RESP_OUT=4'b1011; repeat with 4'b0100 back-to-back (START in cycle 11) → RESP_OUT=4'b0100.
3. Ignored START: hold START=1 through a whole operation → exactly one DONE per 11 cycles; PAT_IN changes while BUSY have no effect on TI.
4. ABORT: assert ABORT in cycle 7 (SHIFT_OUT) → IDLE in cycle 8, TE=0, BUSY=0, no DONE; RESP_OUT[3] written, bits [2:0] retain their prior values.
5. Reset mid-op: RST=1 in cycle 3 → next cycle all outputs at reset values, RESP_OUT=0; a following START completes normally.
6. START+ABORT together in IDLE → operation starts; DONE after 10 cycles.
